// File: rtl/load_store_unit_if.sv
// Bundle of processor-side request/response signals and d_mem bus signals for
// the load/store unit. The LSU takes the master view (it masters d_mem and
// answers the processor); the environment takes the slave view.
interface load_store_unit_if;
    logic        req;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        MemRead;
    logic        MemWrite;

    modport master (
        input  req, op, addr, wdata, ReadData,
        output busy, done, err, rdata, Address, WriteData, MemRead, MemWrite
    );

    modport slave (
        output req, op, addr, wdata, ReadData,
        input  busy, done, err, rdata, Address, WriteData, MemRead, MemWrite
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into
// word-addressed d_mem cycles. Sub-word stores are read-modify-write.
// Optional: define LSU_SUBWORD_EN to build byte/half ops; without it only LW/SW
// are legal and the merge/extract logic is absent.
module load_store_unit #(
    parameter int unsigned MemSize = 10
) (
    input logic                clock,
    input logic                reset,
    load_store_unit_if.master  bus
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

    localparam logic [3:0] OpLw = 4'b0010;
    localparam logic [3:0] OpSw = 4'b1010;
`ifdef LSU_SUBWORD_EN
    localparam logic [3:0] OpLb  = 4'b0000;
    localparam logic [3:0] OpLh  = 4'b0001;
    localparam logic [3:0] OpLbu = 4'b0100;
    localparam logic [3:0] OpLhu = 4'b0101;
    localparam logic [3:0] OpSb  = 4'b1000;
    localparam logic [3:0] OpSh  = 4'b1001;

    logic [3:0]  op_q;
    logic [1:0]  lane_q;
    logic [15:0] wlo_q;

    // op[2] selects zero extension, op[1:0] selects byte/half/word.
    function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] lane,
                                            input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (op[1:0])
            2'b00:   extract = op[2] ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   extract = op[2] ? {16'd0, h} : {{16{h[15]}}, h};
            default: extract = word;
        endcase
    endfunction

    // Little-endian lane replace; half selects SH over SB.
    function automatic logic [31:0] merge(input logic half, input logic [1:0] lane,
                                          input logic [15:0] wd, input logic [31:0] word);
        logic [31:0] w;
        w = word;
        if (half) begin
            if (lane[1]) w[31:16] = wd;
            else         w[15:0]  = wd;
        end else begin
            w[{lane, 3'b000} +: 8] = wd[7:0];
        end
        return w;
    endfunction
`endif

    state_e state_q;
    logic   op_legal;
    logic   misaligned;
    logic   out_of_range;
    logic   req_err;

    // Request legality: op code, alignment for its size, and word index range.
    always_comb begin
        op_legal   = 1'b0;
        misaligned = 1'b0;
        case (bus.op)
`ifdef LSU_SUBWORD_EN
            OpLb, OpLbu, OpSb: op_legal = 1'b1;
            OpLh, OpLhu, OpSh: begin
                op_legal   = 1'b1;
                misaligned = bus.addr[0];
            end
`endif
            OpLw, OpSw: begin
                op_legal   = 1'b1;
                misaligned = bus.addr[1:0] != 2'b00;
            end
            default: ;
        endcase
        out_of_range = (bus.addr[31:2] >> MemSize) != 30'd0;
        req_err      = !op_legal || misaligned || out_of_range;
    end

    // Sequencer with registered outputs; strobes follow the state being entered.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= StIdle;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.rdata     <= 32'd0;
            bus.Address   <= 32'd0;
            bus.WriteData <= 32'd0;
            bus.MemRead   <= 1'b0;
            bus.MemWrite  <= 1'b0;
`ifdef LSU_SUBWORD_EN
            op_q          <= 4'd0;
            lane_q        <= 2'd0;
            wlo_q         <= 16'd0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.req) begin
                        bus.busy <= 1'b1;
`ifdef LSU_SUBWORD_EN
                        op_q   <= bus.op;
                        lane_q <= bus.addr[1:0];
                        wlo_q  <= bus.wdata[15:0];
`endif
                        if (req_err) begin
                            state_q  <= StResp;
                            bus.done <= 1'b1;
                            bus.err  <= 1'b1;
                        end else if (bus.op == OpSw) begin
                            state_q       <= StWr;
                            bus.MemWrite  <= 1'b1;
                            bus.Address   <= {2'b00, bus.addr[31:2]};
                            bus.WriteData <= bus.wdata;
                        end else begin
                            state_q     <= StRd;
                            bus.MemRead <= 1'b1;
                            bus.Address <= {2'b00, bus.addr[31:2]};
                        end
                    end
                end
                StRd: begin
                    bus.MemRead <= 1'b0;
`ifdef LSU_SUBWORD_EN
                    if (op_q[3]) begin
                        state_q       <= StWr;
                        bus.MemWrite  <= 1'b1;
                        bus.WriteData <= merge(op_q[0], lane_q, wlo_q, bus.ReadData);
                    end else begin
                        state_q   <= StResp;
                        bus.done  <= 1'b1;
                        bus.err   <= 1'b0;
                        bus.rdata <= extract(op_q[2:0], lane_q, bus.ReadData);
                    end
`else
                    state_q   <= StResp;
                    bus.done  <= 1'b1;
                    bus.err   <= 1'b0;
                    bus.rdata <= bus.ReadData;
`endif
                end
                StWr: begin
                    state_q      <= StResp;
                    bus.MemWrite <= 1'b0;
                    bus.done     <= 1'b1;
                    bus.err      <= 1'b0;
                end
                StResp: begin
                    state_q  <= StIdle;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    bus.err  <= 1'b0;
                end
                default: begin
                    state_q      <= StIdle;
                    bus.busy     <= 1'b0;
                    bus.done     <= 1'b0;
                    bus.MemRead  <= 1'b0;
                    bus.MemWrite <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word memory model and a scoreboard
// of expected responses (err, rdata, latency).
module tb_load_store_unit;

    localparam int unsigned MemSize = 10;
`ifdef LSU_SUBWORD_EN
    localparam bit Sub = 1'b1;
`else
    localparam bit Sub = 1'b0;
`endif

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic mem_init = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] model_rdata = 32'd0;
    exp_t sb[$];

    always #5 clock = ~clock;

    load_store_unit_if bus ();

    load_store_unit #(.MemSize(MemSize)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [0:1023];

    assign bus.ReadData = mem[bus.Address[9:0]];

    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
            mem[3] <= 32'h8899AABB;
        end else if (bus.MemWrite) begin
            mem[bus.Address[9:0]] <= bus.WriteData;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request, watch strobes until done, compare against scoreboard.
    task automatic run_req(input string tag, input logic [3:0] o, input logic [31:0] a,
                           input logic [31:0] wd, input int lat, input int nrd_exp,
                           input int nwr_exp, input logic e, input logic is_load,
                           input logic [31:0] exp_rd, input logic [31:0] exp_wd);
        int   cyc;
        int   nrd;
        int   nwr;
        logic got;
        exp_t x;
        if (is_load && !e) model_rdata = exp_rd;
        sb.push_back('{e, model_rdata, lat});
        @(negedge clock);
        bus.req   = 1'b1;
        bus.op    = o;
        bus.addr  = a;
        bus.wdata = wd;
        @(negedge clock);
        bus.req = 1'b0;
        cyc = 1;
        nrd = 0;
        nwr = 0;
        got = 1'b0;
        while (!got && cyc <= 8) begin
            if (bus.MemRead) begin
                nrd++;
                chk({tag, " rd Address"}, bus.Address, {2'b00, a[31:2]});
            end
            if (bus.MemWrite) begin
                nwr++;
                chk({tag, " wr Address"}, bus.Address, {2'b00, a[31:2]});
                chk({tag, " WriteData"}, bus.WriteData, exp_wd);
            end
            chk({tag, " strobe overlap"}, {31'd0, bus.MemRead & bus.MemWrite}, 32'd0);
            if (bus.done) begin
                got = 1'b1;
                x = sb.pop_front();
                chk({tag, " latency"}, cyc, x.lat);
                chk({tag, " err"}, {31'd0, bus.err}, {31'd0, x.err});
                chk({tag, " rdata"}, bus.rdata, x.rdata);
                chk({tag, " busy at done"}, {31'd0, bus.busy}, 32'd1);
            end else begin
                @(negedge clock);
                cyc++;
            end
        end
        chk({tag, " done seen"}, {31'd0, got}, 32'd1);
        if (!got) void'(sb.pop_front());
        chk({tag, " read cycles"}, nrd, nrd_exp);
        chk({tag, " write cycles"}, nwr, nwr_exp);
        @(negedge clock);
        chk({tag, " idle done"}, {31'd0, bus.done}, 32'd0);
        chk({tag, " idle busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, " done"}, {31'd0, bus.done}, 32'd0);
        chk({tag, " err"}, {31'd0, bus.err}, 32'd0);
        chk({tag, " MemRead"}, {31'd0, bus.MemRead}, 32'd0);
        chk({tag, " MemWrite"}, {31'd0, bus.MemWrite}, 32'd0);
        chk({tag, " rdata"}, bus.rdata, 32'd0);
        chk({tag, " Address"}, bus.Address, 32'd0);
        chk({tag, " WriteData"}, bus.WriteData, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mem3_exp;
        int nd;
        int nr;
        int nw;
        bus.req   = 1'b0;
        bus.op    = 4'd0;
        bus.addr  = 32'd0;
        bus.wdata = 32'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        mem_init = 1'b0;
        chk_zero("reset");
        reset = 1'b1;

        run_req("LW 0C", 4'b0010, 32'h0C, 32'd0, 2, 1, 0, 1'b0, 1'b1, 32'h8899AABB, 32'd0);
        run_req("LB 0F", 4'b0000, 32'h0F, 32'd0, Sub ? 2 : 1, Sub ? 1 : 0, 0, !Sub, 1'b1,
                32'hFFFFFF88, 32'd0);
        run_req("LBU 0F", 4'b0100, 32'h0F, 32'd0, Sub ? 2 : 1, Sub ? 1 : 0, 0, !Sub, 1'b1,
                32'h00000088, 32'd0);
        run_req("LH 0E", 4'b0001, 32'h0E, 32'd0, Sub ? 2 : 1, Sub ? 1 : 0, 0, !Sub, 1'b1,
                32'hFFFF8899, 32'd0);
        run_req("LHU 0C", 4'b0101, 32'h0C, 32'd0, Sub ? 2 : 1, Sub ? 1 : 0, 0, !Sub, 1'b1,
                32'h0000AABB, 32'd0);
        run_req("SB 0D", 4'b1000, 32'h0D, 32'h12345677, Sub ? 3 : 1, Sub ? 1 : 0,
                Sub ? 1 : 0, !Sub, 1'b0, 32'd0, 32'h889977BB);
        chk("SB mem[3]", mem[3], Sub ? 32'h889977BB : 32'h8899AABB);
        run_req("SW 0C", 4'b1010, 32'h0C, 32'h8899AABB, 2, 0, 1, 1'b0, 1'b0, 32'd0,
                32'h8899AABB);
        run_req("SH 0E", 4'b1001, 32'h0E, 32'h0000CAFE, Sub ? 3 : 1, Sub ? 1 : 0,
                Sub ? 1 : 0, !Sub, 1'b0, 32'd0, 32'hCAFEAABB);
        mem3_exp = Sub ? 32'hCAFEAABB : 32'h8899AABB;
        chk("SH mem[3]", mem[3], mem3_exp);
        run_req("SW 10", 4'b1010, 32'h10, 32'hDEADBEEF, 2, 0, 1, 1'b0, 1'b0, 32'd0,
                32'hDEADBEEF);
        chk("SW mem[4]", mem[4], 32'hDEADBEEF);

        run_req("LW mis 0E", 4'b0010, 32'h0E, 32'd0, 1, 0, 0, 1'b1, 1'b1, 32'd0, 32'd0);
        run_req("LH mis 0D", 4'b0001, 32'h0D, 32'd0, 1, 0, 0, 1'b1, 1'b1, 32'd0, 32'd0);
        run_req("SW mis 11", 4'b1010, 32'h11, 32'h1, 1, 0, 0, 1'b1, 1'b0, 32'd0, 32'd0);
        run_req("LW range 1000", 4'b0010, 32'h1000, 32'd0, 1, 0, 0, 1'b1, 1'b1, 32'd0, 32'd0);
        run_req("illegal 0011", 4'b0011, 32'h0C, 32'd0, 1, 0, 0, 1'b1, 1'b1, 32'd0, 32'd0);
        run_req("LW last FFC", 4'b0010, 32'hFFC, 32'd0, 2, 1, 0, 1'b0, 1'b1, 32'd0, 32'd0);
        run_req("LW 10", 4'b0010, 32'h10, 32'd0, 2, 1, 0, 1'b0, 1'b1, 32'hDEADBEEF, 32'd0);

        // Reset while in RD abandons the access.
        @(negedge clock);
        bus.req  = 1'b1;
        bus.op   = Sub ? 4'b1000 : 4'b0010;
        bus.addr = Sub ? 32'h0D : 32'h0C;
        bus.wdata = 32'h000000EE;
        @(negedge clock);
        bus.req = 1'b0;
        chk("rst-mid MemRead", {31'd0, bus.MemRead}, 32'd1);
        reset = 1'b0;
        @(negedge clock);
        chk_zero("rst-mid");
        reset = 1'b1;
        model_rdata = 32'd0;
        nd = 0;
        nw = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.done) nd++;
            if (bus.MemWrite) nw++;
            @(negedge clock);
        end
        chk("rst-mid writes", nw, 0);
        chk("rst-mid dones", nd, 0);
        chk("rst-mid mem[3]", mem[3], mem3_exp);

        // req held while busy and through RESP is ignored.
        bus.req   = 1'b1;
        bus.op    = 4'b1010;
        bus.addr  = 32'h14;
        bus.wdata = 32'h11111111;
        @(negedge clock);
        chk("busy-req busy", {31'd0, bus.busy}, 32'd1);
        bus.op   = 4'b0010;
        bus.addr = 32'h0C;
        nd = 0;
        nr = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done) nd++;
            if (bus.MemRead) nr++;
            if (i == 2) bus.req = 1'b0;
            @(negedge clock);
        end
        chk("busy-req dones", nd, 1);
        chk("busy-req reads", nr, 0);
        chk("busy-req mem[5]", mem[5], 32'h11111111);
        chk("busy-req rdata", bus.rdata, model_rdata);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator for the word-addressed data memory (d_mem). Converts processor byte-addressed load/store requests (LB/LBU/LH/LHU/LW/SB/SH/SW) into d_mem cycles on Address/WriteData/MemRead/MemWrite/ReadData. Sub-word stores use read-modify-write. Sits between the datapath's memory stage and d_mem, with a busy/done handshake back to control.

Parameters:
MemSize, 10, log2 of d_mem depth in 32-bit words; must equal the d_mem instance value.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
req  input  1  request strobe; sampled only in IDLE
op  input  4  0000 LB, 0001 LH, 0010 LW, 0100 LBU, 0101 LHU, 1000 SB, 1001 SH, 1010 SW; all other codes illegal
addr  input  32  byte address
wdata  input  32  store data; low byte/half used for SB/SH
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse
err  output  1  valid with done: misaligned, out of range, or illegal op
rdata  output  32  load result, extended to 32 bits
Address  output  32  word index to d_mem (addr >> 2)
WriteData  output  32  word to d_mem
ReadData  input  32  word from d_mem; combinational, valid in the same cycle as MemRead
MemRead  output  1  d_mem read strobe
MemWrite  output  1  d_mem write strobe

Behaviour:
- Reset: reset low at a rising edge forces the following on the next edge: state=IDLE; busy, done, err, MemRead, MemWrite = 0; rdata, Address, WriteData = 0. Reset mid-operation abandons the access. No partial write follows reset.
- All outputs are registered. Memory strobes are Moore-decoded from state.
- MemRead and MemWrite are never high in the same cycle.
- States: IDLE, RD, WR, RESP.
- IDLE + req: latch op, addr, wdata. Then check:
  - Illegal op -> RESP with err=1.
  - Misaligned (LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]=1) -> RESP with err=1.
  - addr[31:2] > 2^MemSize-1 -> RESP with err=1.
  - Errored requests issue no memory strobe.
- Otherwise:
  - Loads and SB/SH -> RD.
  - SW -> WR with WriteData=wdata.
- RD: MemRead=1. ReadData is captured at the end of the cycle.
  - Loads -> RESP.
  - SB/SH -> WR with the merged word.
- Merge (little-endian): SB replaces byte lane addr[1:0]; SH replaces half lane addr[1] (lane 0 = bits 15:0). Other lanes keep the captured word.
- WR: MemWrite=1 for exactly one cycle. -> RESP.
- RESP: done=1 for one cycle; err is valid. -> IDLE.
  - Loads: rdata updates at the RD->RESP edge.
  - Stores and errored requests leave rdata unchanged.
- Load extraction: LB/LH sign-extend from bit 7/15 of the selected lane; LBU/LHU zero-extend.
- Latency from req edge to done: LW/loads 2 cycles; SW 2; SB/SH 3; error 1.
- req while busy is ignored and not queued. req in the RESP cycle is ignored.
- Address holds its last value outside RD/WR. MemRead/MemWrite are 0 in IDLE and RESP.

Optional Feature:
LSU_SUBWORD_EN
- Defined: full op set as above.
- Undefined: only LW and SW are legal. LB/LH/LBU/LHU/SB/SH are treated as illegal ops (err=1, 1-cycle latency, no memory strobe). The merge and extraction logic is not built.

Test Plan:
- mem[3]=0x8899AABB; LW addr=0x0C -> MemRead for 1 cycle with Address=3; done 2 cycles after req; rdata=0x8899AABB; err=0.
- Same word; LB addr=0x0F -> rdata=0xFFFFFF88. LBU addr=0x0F -> 0x00000088. LH addr=0x0E -> 0xFFFF8899. LHU addr=0x0C -> 0x0000AABB.
- mem[3]=0x8899AABB; SB addr=0x0D, wdata=0x12345677 -> RD then WR cycles; WriteData=0x889977BB; done 3 cycles after req; rdata unchanged.
- SH addr=0x0E, wdata=0xCAFE over 0x8899AABB -> WriteData=0xCAFEAABB. SW addr=0x10, wdata=0xDEADBEEF -> mem[4]=0xDEADBEEF in 2 cycles, with no MemRead cycle.
- LW addr=0x0E -> err=1; LH addr=0x0D -> err=1; LW addr=0x1000 with MemSize=10 -> err=1; op=0011 -> err=1. Each: done 1 cycle after req, MemRead and MemWrite never asserted.
- Reset mid-operation: SB issued, reset low during RD -> next edge IDLE with all outputs 0, MemWrite never asserted, memory unchanged. req pulsed while busy -> ignored, exactly one done.
